// File: rtl/adc_sample_scheduler_if.sv
// ADC scheduler bundle: rate/channel config, SPI engine handshake,
// sample consumer handshake and sticky status flags.
interface adc_sample_scheduler_if #(
  parameter int DIV_WIDTH = 16
);
  logic                 enable;
  logic                 alt_mode;
  logic                 ch_cfg;
  logic [DIV_WIDTH-1:0] rate_div;
  logic                 clr_flags;
  logic                 conv_done;
  logic [11:0]          conv_data;
  logic                 start_read;
  logic                 ch_sel;
  logic                 busy;
  logic [11:0]          sample_data;
  logic                 sample_ch;
  logic                 sample_valid;
  logic                 sample_ready;
  logic                 overrun;
  logic                 timeout_err;

  modport master (
    output enable, alt_mode, ch_cfg, rate_div,
    output clr_flags, conv_done, conv_data,
    output sample_ready,
    input  start_read, ch_sel, busy,
    input  sample_data, sample_ch, sample_valid,
    input  overrun, timeout_err
  );

  modport slave (
    input  enable, alt_mode, ch_cfg, rate_div,
    input  clr_flags, conv_done, conv_data,
    input  sample_ready,
    output start_read, ch_sel, busy,
    output sample_data, sample_ch, sample_valid,
    output overrun, timeout_err
  );
endinterface

// File: rtl/adc_sample_scheduler.sv
// Periodic ADC conversion scheduler with one-deep result register.
// Define ADC_SCHED_TIMEOUT_EN to abort conversions stuck in BUSY.
module adc_sample_scheduler #(
  parameter int DIV_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                   clk,
  input logic                   reset,
  adc_sample_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_STORE
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 tick;
  logic                 tmo;
  logic                 alt_q, alt_d;
  logic                 ch_q, ch_d;
  logic [11:0]          cap_q, cap_d;
  logic [11:0]          data_q, data_d;
  logic                 sch_q, sch_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;
  logic                 to_q, to_d;

  // >= keeps the timer from running away if rate_div shrinks mid-count
  assign tick = bus.enable && (cnt_q >= bus.rate_div);

  always_comb begin
    cnt_d = '0;
    if (bus.enable && !tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

`ifdef ADC_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = '0;
    if (state_q == S_BUSY) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  assign tmo = (state_q == S_BUSY) &&
               (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    alt_d   = alt_q;
    ch_d    = ch_q;
    cap_d   = cap_q;
    data_d  = data_q;
    sch_d   = sch_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    to_d    = to_q;
    if (bus.clr_flags) begin
      ovr_d = 1'b0;
      to_d  = 1'b0;
    end
    if (valid_q && bus.sample_ready) begin
      valid_d = 1'b0;
    end
    unique case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d = S_START;
          ch_d    = bus.alt_mode ? alt_q : bus.ch_cfg;
        end
      end
      S_START: begin
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (bus.conv_done) begin
          state_d = S_STORE;
          cap_d   = bus.conv_data;
        end else if (tmo) begin
          state_d = S_IDLE;
          to_d    = 1'b1;
        end
      end
      S_STORE: begin
        state_d = S_IDLE;
        data_d  = cap_q;
        sch_d   = ch_q;
        valid_d = 1'b1;
        if (valid_q && !bus.sample_ready) begin
          ovr_d = 1'b1;
        end
        if (bus.alt_mode) begin
          alt_d = ~alt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      alt_q   <= 1'b0;
      ch_q    <= 1'b0;
      cap_q   <= '0;
      data_q  <= '0;
      sch_q   <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alt_q   <= alt_d;
      ch_q    <= ch_d;
      cap_q   <= cap_d;
      data_q  <= data_d;
      sch_q   <= sch_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      to_q    <= to_d;
    end
  end

  assign bus.start_read   = (state_q == S_START);
  assign bus.busy         = (state_q == S_START) ||
                            (state_q == S_BUSY);
  assign bus.ch_sel       = ch_q;
  assign bus.sample_data  = data_q;
  assign bus.sample_ch    = sch_q;
  assign bus.sample_valid = valid_q;
  assign bus.overrun      = ovr_q;
  assign bus.timeout_err  = to_q;

endmodule
